// File: rtl/exec_wb_stage.sv
// Purpose : execute/writeback stage behind the 16x16 register file; ALU op plus iterative MUL, status flags Z/N/C/F.
// Latency : single-cycle ops write back 1 cycle after issue; MUL writes back WIDTH+1 cycles after issue (busy for WIDTH cycles).
// Backpress: busy=1 while MUL iterates; start is ignored then and upstream must hold the instruction until busy=0.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   start, op, dest      issue strobe, opcode (0 ADD .. 8 CMP, 9-15 NOP), destination register
//   srcA, srcB, imm      register-file operands and immediate; use_imm selects imm as operand B
//   busy                 high while a MUL is iterating
//   wb_write/addr/data   one-cycle write request to the register-file write port
//   flag_z/n/c/f         zero, negative, carry/borrow, signed overflow
module exec_wb_stage #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [AW-1:0]    dest,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [WIDTH-1:0] imm,
  input  logic             use_imm,
  output logic             busy,
  output logic             wb_write,
  output logic [AW-1:0]    wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_f
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_MOV = 4'd5;
  localparam logic [3:0] OP_LSH = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_CMP = 4'd8;

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, MULT} state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;     // multiplicand, shifted left each step
  logic [WIDTH-1:0] mplier;    // multiplier, shifted right each step
  logic [WIDTH-1:0] acc;       // partial product (low WIDTH bits only are needed)
  logic [CNT_W-1:0] stepCnt;
  logic [AW-1:0]    mulDest;

  // Operand B and the single-cycle ALU, evaluated straight from the issue inputs.
  logic [WIDTH-1:0] opB;
  logic [WIDTH:0]   sumExt;
  logic [WIDTH:0]   diffExt;     // MSB is the borrow
  logic [4:0]       shMag;       // magnitude of a negative shift count
  logic [WIDTH-1:0] lshRes;
  logic [WIDTH-1:0] aluRes;
  logic             aluC;
  logic             aluF;
  logic             aluWr;
  logic             aluUpd;
  logic [WIDTH-1:0] accNext;

  assign opB     = use_imm ? imm : srcB;
  assign sumExt  = {1'b0, srcA} + {1'b0, opB};
  assign diffExt = {1'b0, srcA} - {1'b0, opB};
  assign shMag   = 5'd0 - opB[4:0];
  // B[4:0] is a signed count: non-negative shifts left, negative shifts right (-16 clears).
  assign lshRes  = opB[4] ? (srcA >> shMag) : (srcA << opB[3:0]);
  assign accNext = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    aluRes = '0;
    aluC   = 1'b0;
    aluF   = 1'b0;
    aluWr  = 1'b0;
    aluUpd = 1'b0;
    case (op)
      OP_ADD: begin
        aluRes = sumExt[WIDTH-1:0];
        aluC   = sumExt[WIDTH];
        aluF   = (srcA[WIDTH-1] == opB[WIDTH-1]) && (aluRes[WIDTH-1] != srcA[WIDTH-1]);
        aluWr  = 1'b1;
        aluUpd = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        aluRes = diffExt[WIDTH-1:0];
        aluC   = diffExt[WIDTH];
        aluF   = (srcA[WIDTH-1] != opB[WIDTH-1]) && (aluRes[WIDTH-1] != srcA[WIDTH-1]);
        aluWr  = (op == OP_SUB);
        aluUpd = 1'b1;
      end
      OP_AND: begin aluRes = srcA & opB; aluWr = 1'b1; aluUpd = 1'b1; end
      OP_OR:  begin aluRes = srcA | opB; aluWr = 1'b1; aluUpd = 1'b1; end
      OP_XOR: begin aluRes = srcA ^ opB; aluWr = 1'b1; aluUpd = 1'b1; end
      OP_MOV: begin aluRes = opB;        aluWr = 1'b1; aluUpd = 1'b1; end
      OP_LSH: begin aluRes = lshRes;     aluWr = 1'b1; aluUpd = 1'b1; end
      default: begin
        // MUL is handled by the FSM; NOPs leave everything untouched.
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      wb_write <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      flag_z   <= 1'b0;
      flag_n   <= 1'b0;
      flag_c   <= 1'b0;
      flag_f   <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      stepCnt  <= '0;
      mulDest  <= '0;
    end else begin
      wb_write <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op == OP_MUL) begin
              mcand   <= srcA;
              mplier  <= opB;
              acc     <= '0;
              stepCnt <= '0;
              mulDest <= dest;
              busy    <= 1'b1;
              state   <= MULT;
            end else begin
              if (aluWr) begin
                wb_write <= 1'b1;
                wb_addr  <= dest;
                wb_data  <= aluRes;
              end
              if (aluUpd) begin
                flag_z <= (aluRes == '0);
                flag_n <= aluRes[WIDTH-1];
                flag_c <= aluC;
                flag_f <= aluF;
              end
            end
          end
        end
        MULT: begin
          acc     <= accNext;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          stepCnt <= stepCnt + 1'b1;
          if (stepCnt == LAST_STEP) begin
            // Final step: the product leaves straight from accNext; C and F keep their values.
            busy     <= 1'b0;
            wb_write <= 1'b1;
            wb_addr  <= mulDest;
            wb_data  <= accNext;
            flag_z   <= (accNext == '0);
            flag_n   <= accNext[WIDTH-1];
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_wb_stage.sv
module tb_exec_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [3:0]  dest;
  logic [15:0] srcA, srcB, imm;
  logic        use_imm;
  logic        busy, wb_write;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        flag_z, flag_n, flag_c, flag_f;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the stage should be presenting right now.
  logic        mWr;
  logic [3:0]  mAddr;
  logic [15:0] mData;
  logic        mZ, mN, mC, mF;

  exec_wb_stage #(.WIDTH(16), .AW(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .dest(dest),
    .srcA(srcA), .srcB(srcB), .imm(imm), .use_imm(use_imm),
    .busy(busy), .wb_write(wb_write), .wb_addr(wb_addr), .wb_data(wb_data),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_f(flag_f)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic expBusy);
    chk({tag, ".busy"}, busy, expBusy);
    chk({tag, ".wr"}, wb_write, mWr);
    chk({tag, ".addr"}, wb_addr, mAddr);
    chk({tag, ".data"}, wb_data, mData);
    chk({tag, ".z"}, flag_z, mZ);
    chk({tag, ".n"}, flag_n, mN);
    chk({tag, ".c"}, flag_c, mC);
    chk({tag, ".f"}, flag_f, mF);
  endtask

  task automatic modelReset();
    mWr = 0; mAddr = 0; mData = 0; mZ = 0; mN = 0; mC = 0; mF = 0;
  endtask

  // Single-cycle ops from the arithmetic definitions (unsigned/signed integer ranges).
  task automatic modelOp(input logic [3:0] o, input logic [3:0] d, input logic [15:0] a, input logic [15:0] b);
    int ua, ub, sa, sb, full, s, sh;
    logic [15:0] r;
    logic wr, upd, c, f;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    r = 0; wr = 0; upd = 1; c = 0; f = 0;
    case (o)
      4'd0: begin full = ua + ub; r = 16'(full); c = (full > 65535); s = sa + sb;
                  f = (s > 32767) || (s < -32768); wr = 1; end
      4'd1, 4'd8: begin full = ua - ub; r = 16'(full); c = (ua < ub); s = sa - sb;
                  f = (s > 32767) || (s < -32768); wr = (o == 4'd1); end
      4'd2: begin r = a & b; wr = 1; end
      4'd3: begin r = a | b; wr = 1; end
      4'd4: begin r = a ^ b; wr = 1; end
      4'd5: begin r = b; wr = 1; end
      4'd6: begin
        sh = $signed(b[4:0]);
        if (sh >= 0) r = 16'(ua << sh);
        else         r = 16'(ua >> (-sh));
        wr = 1;
      end
      default: upd = 0;
    endcase
    if (upd) begin mZ = (r == 0); mN = r[15]; mC = c; mF = f; end
    if (wr) begin mAddr = d; mData = r; end
    mWr = wr;
  endtask

  task automatic doOp(input string tag, input logic [3:0] o, input logic [3:0] d, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] im, input logic u);
    op = o; dest = d; srcA = a; srcB = b; imm = im; use_imm = u; start = 1;
    @(posedge clk); @(negedge clk);
    start = 0;
    modelOp(o, d, a, u ? im : b);
    checkAll(tag, 1'b0);
  endtask

  task automatic idle(input string tag);
    start = 0;
    @(posedge clk); @(negedge clk);
    mWr = 0;
    checkAll(tag, 1'b0);
  endtask

  // inject: busy cycle on which an ADD start is pulsed (0 = none); abortAt: busy cycle to assert reset (0 = none).
  task automatic doMul(input string tag, input logic [3:0] d, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] im, input logic u, input int inject, input int abortAt);
    int n, extra;
    logic [15:0] bEff, r;
    bEff = u ? im : b;
    op = 4'd7; dest = d; srcA = a; srcB = b; imm = im; use_imm = u; start = 1;
    @(posedge clk); @(negedge clk);
    start = 0;
    n = 0; extra = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (wb_write !== 1'b0) extra++;
      if (n == abortAt) begin
        start = 0; reset = 1;
        @(posedge clk); @(negedge clk);
        reset = 0;
        modelReset();
        checkAll({tag, ".abort"}, 1'b0);
        extra = 0;
        repeat (20) begin @(negedge clk); if (wb_write !== 1'b0) extra++; end
        chk({tag, ".abort_no_wb"}, extra, 0);
        return;
      end
      if (n == inject) begin
        start = 1; op = 4'd0; dest = ~d; srcA = 16'($urandom); srcB = 16'($urandom);
      end else begin
        start = 0;
      end
      @(negedge clk);
    end
    start = 0;
    chk({tag, ".busy_cycles"}, n, 16);
    chk({tag, ".extra_wb"}, extra, 0);
    r = 16'(longint'(a) * longint'(bEff));
    mWr = 1; mAddr = d; mData = r; mZ = (r == 0); mN = r[15];
    checkAll(tag, 1'b0);
  endtask

  initial begin
    reset = 1; start = 0; op = 0; dest = 0; srcA = 0; srcB = 0; imm = 0; use_imm = 0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAll("reset", 1'b0);
    reset = 0;
    idle("post_reset");

    // ADD with signed overflow into the sign bit
    doOp("add", 4'd0, 4'd3, 16'h7FFF, 16'h0001, 16'h0000, 1'b0);
    chk("add.const_data", wb_data, 16'h8000);
    chk("add.const_nf", {flag_n, flag_f, flag_c, flag_z}, 4'b1100);
    idle("add_drop");

    // SUB via immediate giving zero, then CMP with borrow
    doOp("sub", 4'd1, 4'd5, 16'h0005, 16'hABCD, 16'h0005, 1'b1);
    chk("sub.const", {wb_data, 3'b0, flag_z, flag_c}, {16'h0000, 3'b0, 1'b1, 1'b0});
    doOp("cmp", 4'd8, 4'd9, 16'h0003, 16'h0004, 16'h0000, 1'b0);
    chk("cmp.const", {wb_write, flag_c, flag_n, flag_z}, 4'b0110);
    idle("cmp_after");

    // LSH left, right, and the -16 boundary
    doOp("lsh_l", 4'd6, 4'd1, 16'h00F0, 16'h0004, 16'h0000, 1'b0);
    chk("lsh_l.const", wb_data, 16'h0F00);
    doOp("lsh_r", 4'd6, 4'd1, 16'h00F0, 16'h001C, 16'h0000, 1'b0);
    chk("lsh_r.const", wb_data, 16'h000F);
    doOp("lsh_m16", 4'd6, 4'd1, 16'h00F0, 16'h0010, 16'h0000, 1'b0);
    chk("lsh_m16.const", {wb_data, flag_z}, {16'h0000, 1'b1});

    // Set C and F, then MUL must leave them alone; an ADD start during busy is ignored
    doOp("add_cf", 4'd0, 4'd2, 16'h8000, 16'h8000, 16'h0000, 1'b0);
    doMul("mul", 4'd7, 16'h0123, 16'h0010, 16'h0000, 1'b0, 5, 0);
    chk("mul.const", {wb_data, flag_c, flag_f}, {16'h1230, 1'b1, 1'b1});
    idle("mul_drop");

    // Reset 8 cycles into a MUL, then a fresh MUL followed back-to-back by ADD
    doMul("mul_abort", 4'd4, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 0, 8);
    doMul("mul_3x5", 4'd6, 16'h0003, 16'h0005, 16'h0000, 1'b0, 0, 0);
    chk("mul_3x5.const", wb_data, 16'h000F);
    doOp("b2b_add", 4'd0, 4'd8, 16'h1111, 16'h2222, 16'h0000, 1'b0);
    idle("b2b_drop");

    // Randomized mix against the reference model
    for (int i = 0; i < 80; i++) begin
      logic [3:0] ro;
      ro = 4'($urandom_range(0, 15));
      if (ro == 4'd7)
        doMul("rnd_mul", 4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
              $urandom_range(0, 15), 0);
      else
        doOp("rnd_op", ro, 4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle("rnd_idle");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
